// File: rtl/seq_approx_divider.sv
// Sequential restoring divider (2N / N), one quotient bit per cycle, whose low
// subtractor columns can switch to an approximate difference cell per operation.
module seq_approx_divider #(
    parameter int N           = 8,
    parameter int APPROX_COLS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] n,
    input  logic [N-1:0]   d,
    input  logic           approx_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           ovf,
    output logic           dz
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] n_q, n_d;
    logic [N-1:0]   d_q, d_d;
    logic           apx_q, apx_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    // Trial subtraction T - {0,d}: N full columns plus a borrow-only top column.
    logic [N:0]     t_w;
    logic [N-1:0]   s_w;
    logic [N:0]     b_w;
    logic           borrow_out;
    logic           take;
    logic [N-1:0]   rem_step;

    assign t_w    = {rem_q, n_q[cnt_q]};
    assign b_w[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            logic x_w, y_w, diff_exact;
            assign x_w        = t_w[gi];
            assign y_w        = d_q[gi];
            assign diff_exact = x_w ^ y_w ^ b_w[gi];
            assign b_w[gi+1]  = (~x_w & y_w) | (~(x_w ^ y_w) & b_w[gi]);
            if (gi < APPROX_COLS) begin : g_apx
                // Only the difference bit is approximated; the borrow stays exact.
                assign s_w[gi] = apx_q ? x_w : diff_exact;
            end else begin : g_exact
                assign s_w[gi] = diff_exact;
            end
        end
    endgenerate

    assign borrow_out = ~t_w[N] & b_w[N];
    assign take       = t_w[N] | ~borrow_out;
    assign rem_step   = take ? s_w : t_w[N-1:0];

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        apx_d   = apx_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d     = n;
                    d_d     = d;
                    apx_d   = approx_en;
                    rem_d   = n[2*N-1:N];
                    quo_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rem_d        = rem_step;
                quo_d[cnt_q] = take;
                cnt_d        = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    dz_d    = (d_q == '0);
                    ovf_d   = (n_q[2*N-1:N] >= d_q);
                    q_d     = dz_d ? '1 : quo_d;
                    r_d     = dz_d ? n_q[N-1:0] : rem_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            apx_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            apx_q   <= apx_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed and random checks of seq_approx_divider (N=8, APPROX_COLS=2) against
// an arithmetic model of the restoring array with approximate low columns.
module tb_seq_approx_divider;

    localparam int N  = 8;
    localparam int AC = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] n;
    logic [N-1:0]   d;
    logic           approx_en;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           ovf;
    logic           dz;

    int tests;
    int fails;

    logic [N-1:0] exp_q, exp_r;
    logic         exp_ovf, exp_dz;
    logic [N-1:0] got_q, got_r;
    logic         got_ovf, got_dz;

    seq_approx_divider #(.N(N), .APPROX_COLS(AC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Long-division model: exact difference by integer subtraction, with the
    // low AC difference bits replaced by the minuend bits in approximate mode.
    function automatic void model(input logic [2*N-1:0] nn, input logic [N-1:0] dd, input logic ax,
                                  output logic [N-1:0] mq, output logic [N-1:0] mr,
                                  output logic mov, output logic mdz);
        int rem;
        int t;
        int s;
        int mask;
        mask = (1 << AC) - 1;
        rem  = int'(nn[2*N-1:N]);
        mq   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            t = rem * 2 + int'(nn[i]);
            s = (t - int'(dd)) & ((1 << (N + 1)) - 1);
            if (ax) s = (s & ~mask) | (t & mask);
            if (t >= int'(dd)) begin
                mq[i] = 1'b1;
                rem   = s & ((1 << N) - 1);
            end else begin
                rem   = t & ((1 << N) - 1);
            end
        end
        mdz = (dd == '0);
        mov = (nn[2*N-1:N] >= dd);
        mr  = N'(rem);
        if (mdz) begin
            mq = '1;
            mr = nn[N-1:0];
        end
    endfunction

    // Whenever a result is presented it must match the model and the block must refuse input.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("out_q", 32'(q), 32'(exp_q));
            check("out_r", 32'(r), 32'(exp_r));
            check("out_ovf", 32'(ovf), 32'(exp_ovf));
            check("out_dz", 32'(dz), 32'(exp_dz));
            check("in_ready_in_done", 32'(in_ready), 32'd0);
        end
    end

    // One operation: accept, measure latency, optionally stall with junk input, then handshake.
    task automatic run_op(input logic [2*N-1:0] nn, input logic [N-1:0] dd, input logic ax,
                          input int hold, input bit inject);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        model(nn, dd, ax, exp_q, exp_r, exp_ovf, exp_dz);
        n = nn; d = dd; approx_en = ax; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = $urandom; d = 8'($urandom); approx_en = ~ax;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(N));
        got_q = q; got_r = r; got_ovf = ovf; got_dz = dz;
        for (int h = 0; h < hold; h++) begin
            if (inject) begin
                in_valid = 1'b1; n = $urandom; d = 8'($urandom);
            end
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        $display("[TB] op n=%0d d=%0d ax=%0d -> q=%0d r=%0d ovf=%0d dz=%0d", nn, dd, ax, got_q, got_r, got_ovf, got_dz);
    endtask

    initial begin
        logic [2*N-1:0] rn;
        logic [N-1:0]   rd;
        int             cyc;
        tests = 0; fails = 0;
        rst = 1'b1; in_valid = 1'b0; n = '0; d = '0; approx_en = 1'b0; out_ready = 1'b0;
        exp_q = '0; exp_r = '0; exp_ovf = 1'b0; exp_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", {q, r, 6'd0, ovf, dz}, 32'd0);

        run_op(16'd1000, 8'd7, 1'b0, 0, 1'b0);
        check("exact_q", 32'(got_q), 32'd142);
        check("exact_r", 32'(got_r), 32'd6);
        check("exact_flags", {got_ovf, got_dz}, 32'd0);

        run_op(16'd1000, 8'd4, 1'b1, 0, 1'b0);
        check("approx_q", 32'(got_q), 32'd250);
        check("approx_r", 32'(got_r), 32'd0);

        run_op(16'h1234, 8'd0, 1'b0, 0, 1'b0);
        check("dz_flag", 32'(got_dz), 32'd1);
        check("dz_q", 32'(got_q), 32'hFF);
        check("dz_r", 32'(got_r), 32'h34);

        run_op(16'h0900, 8'd8, 1'b0, 0, 1'b0);
        check("ovf_flag", 32'(got_ovf), 32'd1);
        check("ovf_dz", 32'(got_dz), 32'd0);

        run_op(16'd5555, 8'd77, 1'b1, 5, 1'b1);

        // Abort in the 4th BUSY cycle
        n = 16'd4321; d = 8'd13; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_outputs", {q, r, 6'd0, ovf, dz}, 32'd0);
        cyc = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        check("abort_no_valid", 32'(cyc), 32'd0);
        run_op(16'd100, 8'd9, 1'b0, 0, 1'b0);
        check("after_abort_q", 32'(got_q), 32'd11);
        check("after_abort_r", 32'(got_r), 32'd1);

        for (int k = 0; k < 300; k++) begin
            rn = 16'($urandom);
            rd = 8'($urandom);
            if (k % 3 == 0) rn[15:8] = rd - 8'd1;
            run_op(rn, rd, k[0], 0, 1'b0);
            if (!k[0] && !got_ovf && !got_dz) begin
                check("identity", 32'(got_q) * 32'(rd) + 32'(got_r), 32'(rn));
                check("rem_lt_d", 32'(got_r < rd), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
